usr_shift_ctrl: RTL

Upstream sequencer for the team's 8-bit universal shift register (mode 00 hold, 01 shift left with `ser_right` fill, 10 shift right with `ser_left` fill, 11 parallel load). It accepts a shift job over a valid/ready handshake, loads the byte into the register and steps it 0–8 positions. Each step can be logical (constant fill) or rotate, with the fill bit taken from the register's fed-back output. Each bit that leaves the register is presented on a serial output strobe.

---
 rtl/usr_shift_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/usr_shift_ctrl.sv
// usr_shift_ctrl: job sequencer for an external 8-bit universal shift register.
// It accepts a job on a valid/ready handshake and loads the byte into the register.
// It then steps the register 0..8 positions, left or right, as a logical shift or a rotate.
// Each bit that leaves the register is presented on ser_out, qualified by ser_valid.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      job handshake (ready only while idle)
//   in_data/in_dir         byte to load, direction (0 = left, 1 = right)
//   in_count/in_rotate     shift count (clamped to 8), rotate enable
//   usr_q                  shift-register output, fed back
//   usr_mode/usr_par       register mode and parallel-load data
//   usr_ser_left/right     register serial fill inputs
//   ser_out/ser_valid      exiting bit and its qualifier
//   busy/done              job in progress, one-cycle end-of-job pulse
module usr_shift_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter logic        FILL  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_dir,
   input  logic [3:0]       in_count,
   input  logic             in_rotate,
   input  logic [WIDTH-1:0] usr_q,
   output logic [1:0]       usr_mode,
   output logic [WIDTH-1:0] usr_par,
   output logic             usr_ser_left,
   output logic             usr_ser_right,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W   = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(8);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_LEFT  = 2'b01;
   localparam logic [1:0] MODE_RIGHT = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] data_q;
   logic             dir_q;
   logic             rot_q;
   logic             in_ready_q;
   logic [1:0]       mode_q;
   logic             ser_valid_q;
   logic             busy_q;
   logic             done_q;

   logic             shifting;
   logic             exit_bit;
   logic             fill_bit;
   logic [CNT_W-1:0] cnt_clamped;

   // Counts above 8 are clamped to a full-width walk.
   assign cnt_clamped = (in_count > CNT_MAX) ? CNT_MAX : in_count;

   // Sequencer; the registered outputs are loaded with the decode of the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         data_q      <= '0;
         dir_q       <= 1'b0;
         rot_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         mode_q      <= MODE_HOLD;
         ser_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  data_q     <= in_data;
                  dir_q      <= in_dir;
                  rot_q      <= in_rotate;
                  cnt_q      <= cnt_clamped;
                  state_q    <= ST_LOAD;
                  in_ready_q <= 1'b0;
                  mode_q     <= MODE_LOAD;
                  busy_q     <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (cnt_q != '0) begin
                  state_q     <= ST_SHIFT;
                  mode_q      <= dir_q ? MODE_RIGHT : MODE_LEFT;
                  ser_valid_q <= 1'b1;
               end else begin
                  state_q <= ST_DONE;
                  mode_q  <= MODE_HOLD;
                  done_q  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q     <= ST_DONE;
                  mode_q      <= MODE_HOLD;
                  ser_valid_q <= 1'b0;
                  done_q      <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q    <= ST_IDLE;
               in_ready_q <= 1'b1;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
            end
            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               mode_q      <= MODE_HOLD;
               ser_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
            end
         endcase
      end
   end

   // The exiting bit comes straight from the fed-back register value and is masked outside SHIFT.
   assign shifting = (state_q == ST_SHIFT);
   assign exit_bit = shifting ? (dir_q ? usr_q[0] : usr_q[WIDTH-1]) : 1'b0;
   assign fill_bit = (shifting && rot_q) ? exit_bit : FILL;

   assign usr_ser_right = dir_q ? FILL : fill_bit;
   assign usr_ser_left  = dir_q ? fill_bit : FILL;

   assign ser_out   = exit_bit;
   assign ser_valid = ser_valid_q;
   assign in_ready  = in_ready_q;
   assign usr_mode  = mode_q;
   assign usr_par   = data_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
